func_eval_arbiter: RTL and testbench
====================================

# func_eval_arbiter

Shares one registered 8-input Boolean evaluator among NREQ requesters. Each requester presents an 8-bit operand under a valid/ready handshake. A round-robin arbiter grants one requester per cycle into a two-stage pipeline, and the block returns the 1-bit result tagged with the requester ID. It sits between the requesting agents and the evaluator datapath and is the only path by which that datapath is used.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- ID_W, $clog2(NREQ), width of the requester ID
- CNT_W, 16, width of the evaluation counter

Ports:
- clk  in  1  rising-edge clock, single domain
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester operand valid
- req_data  in  NREQ*8  operands; requester i occupies bits [8i+7:8i]
- req_ready  out  NREQ  per-requester accept; at most one bit set (one-hot or zero)
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result consumer ready
- rsp_id  out  ID_W  requester that produced the result
- rsp_y  out  1  evaluated result
- busy  out  1  pipeline holds at least one in-flight item
- eval_count  out  CNT_W  completed responses, wraps modulo 2^CNT_W

## Operation
- Operand bit mapping is a=d[7], b=d[6], c=d[5], d=d[4], e=d[3], f=d[2], g=d[1], h=d[0].
- Function: y = (a&b) | (c^(d&e)) | (f^(g&h)).
- Arbitration is round-robin with pointer `ptr`:
  - Search order is ptr, ptr+1, …, wrapping modulo NREQ.
  - Winner = first requester with req_valid set.
  - On a transfer, ptr becomes winner+1 (modulo NREQ).
  - ptr does not move without a transfer.
- Transfer on requester i = req_valid[i] & req_ready[i].
- req_ready[i] = (i is the winner) & s1_can_load. It is combinational from req_valid, ptr and pipeline state.
- Pipeline:
  - S1 register holds {valid, id, operand}.
  - S2 output register holds {rsp_valid, rsp_id, rsp_y}.
  - s2_can_load = !rsp_valid | rsp_ready.
  - s1_can_load = !s1_valid | s2_can_load.
  - S1→S2 advances when s1_valid & s2_can_load; rsp_y is computed from the S1 operand at that edge.
  - S2 clears when rsp_valid & rsp_ready and nothing new is loaded.
- Requester rules:
  - A requester holds req_data stable while valid and not ready.
  - A requester may drop valid before being granted; no grant is lost, because ptr is unchanged.
- Responses return in acceptance order; the block never drops or reorders an item.
- eval_count increments by 1 on each rsp_valid & rsp_ready, and wraps from 2^CNT_W−1 to 0.
- busy = s1_valid | rsp_valid.

## Timing
- Reset values: ptr=0, s1_valid=0, rsp_valid=0, rsp_id=0, rsp_y=0, eval_count=0, busy=0, req_ready=0.
- Reset mid-operation takes effect immediately (asynchronous) and discards in-flight items. On release, arbitration restarts with requester 0 at top priority.
- Latency: an operand accepted at edge N gives rsp_valid high after edge N+1 with no stall, i.e. two cycles from request to visible response.
- Throughput: one accept and one response per cycle while rsp_ready=1.
- Backpressure: while rsp_valid & !rsp_ready:
  - rsp_id and rsp_y hold stable.
  - S1 may fill once; after that, all req_ready bits are 0.
- Simultaneous S2 drain and S1 advance in the same cycle is a legal full-throughput handoff.

## Structure
- Package func_eval_pkg holds:
  - OPW=8
  - default NREQ
  - function eval_fn(logic [7:0]) returning y
  - typedef s1_t {valid, id, operand}
- Sub-module rr_arbiter:
  - Parameter NREQ.
  - Inputs: req vector, advance strobe.
  - Outputs: one-hot grant, encoded grant_id.
  - Owns ptr.
- The top level holds the pipeline registers, handshake logic and counter.

## Test plan
- Single item: requester 0 sends 8'hC0 with rsp_ready=1 → rsp_valid two cycles later, rsp_id=0, rsp_y=1, eval_count=1.
- Function corners via requester 2, in order: 8'h00, 8'h18, 8'h38, 8'h04, 8'h07 → rsp_y = 0, 1, 0, 1, 0, all with rsp_id=2.
- Fairness: all four req_valid held high and rsp_ready=1 for 8 cycles → grants 0,1,2,3,0,1,2,3 back-to-back; rsp_id follows the same sequence 2 cycles later.
- Backpressure: 3 items accepted, then rsp_ready=0 for 4 cycles → first response held stable, S1 full, req_ready all 0. After release, 3 responses arrive in order with none lost.
- Reset mid-stream: rst pulsed with 2 items in flight → rsp_valid and busy drop immediately, eval_count=0. After release, req 3 and req 1 valid together → req 1 granted first.
- Exhaustive sweep: requester 1 issues all 256 operands with random rsp_ready stalls → every rsp_y matches the model, eval_count=256.

Source files
------------

// File: rtl/func_eval_arbiter_pkg.sv
// Shared types and the Boolean function for the shared evaluator.
// Pure declarations: no latency or flow control lives here.
// S1 id is sized for the largest supported NREQ; the top narrows it.
package func_eval_pkg;

    localparam int OPW          = 8;
    localparam int NREQ_DEFAULT = 4;
    localparam int MAX_ID_W     = 3;

    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
        logic [OPW-1:0]      operand;
    } s1_t;

    // Operand bits map a..h onto d[7]..d[0].
    function automatic logic eval_fn(input logic [OPW-1:0] d);
        return (d[7] & d[6]) | (d[5] ^ (d[4] & d[3])) | (d[2] ^ (d[1] & d[0]));
    endfunction

endpackage

// File: rtl/func_eval_arbiter_if.sv
// Requester/response bundle for the shared evaluator.
// Valid/ready on both sides; req_ready is at most one-hot.
// slave = evaluator side, master = requesters plus response consumer.
interface func_eval_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int ID_W  = $clog2(NREQ),
    parameter int CNT_W = 16
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*8-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [ID_W-1:0]   rsp_id;
    logic              rsp_y;
    logic              busy;
    logic [CNT_W-1:0]  eval_count;

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_y, busy, eval_count
    );

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_y, busy, eval_count
    );

endinterface

// File: rtl/func_eval_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, searching upward from ptr.
// Grant has zero latency; ptr moves to winner+1 only on an advance strobe.
// Without advance the grant stays put, so a dropped request loses no priority.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_id
);

    logic [ID_W-1:0] ptr;
    logic            found;

    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[(int'(ptr) + k) % NREQ]) begin
                found    = 1'b1;
                grant_id = ID_W'((int'(ptr) + k) % NREQ);
            end
        end
        grant = found ? (NREQ'(1) << grant_id) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

endmodule

// File: rtl/func_eval_arbiter.sv
// Shares one registered 8-input Boolean evaluator among NREQ requesters.
// Latency: accept at edge N, rsp_valid visible after edge N+1; one item/cycle.
// Backpressure: stalled S2 holds; S1 fills once, then every req_ready drops.
module func_eval_arbiter
    import func_eval_pkg::*;
#(
    parameter int NREQ  = NREQ_DEFAULT,
    parameter int ID_W  = $clog2(NREQ),
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    func_eval_arbiter_if.slave bus
);

    s1_t              s1_q;
    logic             rsp_valid_q;
    logic [ID_W-1:0]  rsp_id_q;
    logic             rsp_y_q;
    logic [CNT_W-1:0] eval_count_q;

    logic [NREQ-1:0]  grant;
    logic [ID_W-1:0]  grant_id;
    logic [OPW-1:0]   grant_op;
    logic             s2_can_load;
    logic             s1_can_load;
    logic             accept;
    logic             rsp_fire;

    assign s2_can_load = !rsp_valid_q || bus.rsp_ready;
    assign s1_can_load = !s1_q.valid || s2_can_load;
    assign accept      = (|grant) && s1_can_load;
    assign rsp_fire    = rsp_valid_q && bus.rsp_ready;
    assign grant_op    = bus.req_data[grant_id*OPW +: OPW];

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (bus.req_valid),
        .advance  (accept),
        .grant    (grant),
        .grant_id (grant_id)
    );

    // S1 empties whenever it can load but nothing is granted: its item moved on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
        end else if (s1_can_load) begin
            s1_q.valid   <= accept;
            s1_q.id      <= MAX_ID_W'(grant_id);
            s1_q.operand <= grant_op;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_y_q     <= 1'b0;
        end else if (s2_can_load) begin
            rsp_valid_q <= s1_q.valid;
            if (s1_q.valid) begin
                rsp_id_q <= s1_q.id[ID_W-1:0];
                rsp_y_q  <= eval_fn(s1_q.operand);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eval_count_q <= '0;
        end else if (rsp_fire) begin
            eval_count_q <= eval_count_q + 1'b1;
        end
    end

    assign bus.req_ready  = grant & {NREQ{s1_can_load}};
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_y      = rsp_y_q;
    assign bus.busy       = s1_q.valid || rsp_valid_q;
    assign bus.eval_count = eval_count_q;

    a_ready_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(bus.req_ready));

    a_s1_id_range: assert property (@(posedge clk) disable iff (rst)
        s1_q.valid |-> (int'(s1_q.id) < NREQ));

    a_rsp_hold: assert property (@(posedge clk) disable iff (rst)
        (rsp_valid_q && !bus.rsp_ready) |=> (rsp_valid_q && $stable(rsp_id_q) && $stable(rsp_y_q)));

endmodule

// File: tb/tb_func_eval_arbiter.sv
// Randomized and directed bench for func_eval_arbiter against a queue-based reference model.
module tb_func_eval_arbiter;

    localparam int NREQ  = 4;
    localparam int ID_W  = 2;
    localparam int CNT_W = 16;
    localparam int DEPTH = 512;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    func_eval_arbiter_if #(.NREQ(NREQ), .ID_W(ID_W), .CNT_W(CNT_W)) bus ();

    func_eval_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference function written from the named-variable definition.
    function automatic logic ref_y(input logic [7:0] op);
        logic a, b, c, d, e, f, g, h;
        {a, b, c, d, e, f, g, h} = op;
        return (a && b) || (c != (d && e)) || (f != (g && h));
    endfunction

    typedef struct {
        int   id;
        logic y;
        int   acc;
    } item_t;

    // Model: a two-deep in-order queue; the head is visible one edge after acceptance.
    item_t mq[$];
    int    mptr   = 0;
    int    mcnt   = 0;
    int    edge_n = 0;

    logic [7:0] src_mem [NREQ][DEPTH];
    int         src_head [NREQ];
    int         src_tail [NREQ];
    int         vprob = 100;
    int         rprob = 100;

    int   obs_id[$];
    logic obs_y[$];
    int   acc_log[$];

    task automatic push_op(input int i, input logic [7:0] op);
        src_mem[i][src_tail[i]] = op;
        src_tail[i]++;
    endtask

    function automatic int pending();
        int n = mq.size();
        for (int i = 0; i < NREQ; i++) n += src_tail[i] - src_head[i];
        return n;
    endfunction

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (src_head[i] != src_tail[i]) begin
                bus.req_valid[i]     = ($urandom_range(99) < vprob);
                bus.req_data[i*8 +: 8] = src_mem[i][src_head[i]];
            end else begin
                bus.req_valid[i]     = 1'b0;
                bus.req_data[i*8 +: 8] = 8'($urandom);
            end
        end
        bus.rsp_ready = ($urandom_range(99) < rprob);
    endtask

    task automatic step();
        int              win;
        int              enc;
        logic [NREQ-1:0] exp_rdy;
        logic            can, exp_rv, acc, rsp;
        item_t           it;
        drive();
        @(negedge clk);
        win = -1;
        for (int k = 0; k < NREQ; k++) begin
            if (win < 0 && bus.req_valid[(mptr + k) % NREQ]) win = (mptr + k) % NREQ;
        end
        can     = !(mq.size() == 2 && !bus.rsp_ready);
        exp_rdy = '0;
        if (can && win >= 0) exp_rdy[win] = 1'b1;
        exp_rv  = (mq.size() > 0) && (mq[0].acc < edge_n);
        check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
        check("busy", 32'(bus.busy), 32'(mq.size() > 0));
        check("eval_count", 32'(bus.eval_count), 32'(mcnt % 65536));
        if (exp_rv) begin
            check("rsp_id", 32'(bus.rsp_id), 32'(mq[0].id));
            check("rsp_y", 32'(bus.rsp_y), 32'(mq[0].y));
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
            obs_id.push_back(int'(bus.rsp_id));
            obs_y.push_back(bus.rsp_y);
        end
        enc = -1;
        for (int k = 0; k < NREQ; k++) if (bus.req_ready[k]) enc = k;
        if (enc >= 0) acc_log.push_back(enc);
        acc = (exp_rdy != '0);
        rsp = exp_rv && bus.rsp_ready;
        @(posedge clk);
        edge_n++;
        if (rsp) begin
            void'(mq.pop_front());
            mcnt++;
        end
        if (acc) begin
            it.id  = win;
            it.y   = ref_y(src_mem[win][src_head[win]]);
            it.acc = edge_n;
            mq.push_back(it);
            src_head[win]++;
            mptr = (win + 1) % NREQ;
        end
        #1;
    endtask

    task automatic run_idle(input int max_cycles);
        int n = 0;
        while (pending() > 0 && n < max_cycles) begin
            step();
            n++;
        end
        check("drain_timeout", 32'(pending()), 32'd0);
    endtask

    task automatic clear_logs();
        obs_id.delete();
        obs_y.delete();
        acc_log.delete();
    endtask

    // Asserted mid-cycle to exercise the asynchronous path.
    task automatic do_reset();
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        rst = 1'b1;
        #2;
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_eval_count", 32'(bus.eval_count), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        mptr = 0;
        mcnt = 0;
        for (int i = 0; i < NREQ; i++) begin
            src_head[i] = 0;
            src_tail[i] = 0;
        end
    endtask

    initial begin
        logic [7:0] corner_op [5];
        logic       corner_y  [5];
        corner_op = '{8'h00, 8'h18, 8'h38, 8'h04, 8'h07};
        corner_y  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            src_head[i] = 0;
            src_tail[i] = 0;
        end
        @(posedge clk);
        #1;
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
        check("reset_rsp_y", 32'(bus.rsp_y), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_eval_count", 32'(bus.eval_count), 32'd0);
        check("reset_req_ready", 32'(bus.req_ready), 32'd0);
        rst = 1'b0;

        // Single item
        clear_logs();
        push_op(0, 8'hC0);
        run_idle(20);
        check("single_count", 32'(obs_y.size()), 32'd1);
        if (obs_y.size() > 0) begin
            check("single_id", 32'(obs_id[0]), 32'd0);
            check("single_y", 32'(obs_y[0]), 32'd1);
        end
        check("single_eval_count", 32'(bus.eval_count), 32'd1);

        // Function corners through requester 2
        clear_logs();
        for (int k = 0; k < 5; k++) push_op(2, corner_op[k]);
        run_idle(40);
        check("corner_count", 32'(obs_y.size()), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (obs_y.size() > k) begin
                check("corner_y", 32'(obs_y[k]), 32'(corner_y[k]));
                check("corner_id", 32'(obs_id[k]), 32'd2);
            end
        end

        // Fairness from a fresh pointer
        do_reset();
        clear_logs();
        for (int i = 0; i < NREQ; i++) begin
            push_op(i, 8'($urandom));
            push_op(i, 8'($urandom));
        end
        run_idle(40);
        check("fair_grants", 32'(acc_log.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            if (acc_log.size() > k) check("fair_grant_order", 32'(acc_log[k]), 32'(k % 4));
            if (obs_id.size() > k) check("fair_rsp_order", 32'(obs_id[k]), 32'(k % 4));
        end

        // Backpressure
        clear_logs();
        rprob = 0;
        push_op(0, 8'hC0);
        push_op(1, 8'h18);
        push_op(2, 8'h07);
        repeat (4) step();
        check("bp_req_ready_zero", 32'(bus.req_ready), 32'd0);
        check("bp_busy", 32'(bus.busy), 32'd1);
        check("bp_held_id", 32'(bus.rsp_id), 32'd0);
        check("bp_held_y", 32'(bus.rsp_y), 32'd1);
        rprob = 100;
        run_idle(20);
        check("bp_rsp_count", 32'(obs_id.size()), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (obs_id.size() > k) check("bp_rsp_order", 32'(obs_id[k]), 32'(k));
        end

        // Reset mid-stream, then priority restarts at requester 0
        push_op(0, 8'h11);
        push_op(1, 8'h22);
        step();
        step();
        do_reset();
        clear_logs();
        bus.req_valid = 4'b1010;
        #1;
        check("post_reset_grant", 32'(bus.req_ready), 32'b0010);
        push_op(3, 8'hC0);
        push_op(1, 8'h38);
        run_idle(20);
        if (acc_log.size() > 1) begin
            check("post_reset_first", 32'(acc_log[0]), 32'd1);
            check("post_reset_second", 32'(acc_log[1]), 32'd3);
        end
        check("post_reset_count", 32'(obs_id.size()), 32'd2);

        // Exhaustive operand sweep with random stalls
        do_reset();
        clear_logs();
        vprob = 80;
        rprob = 60;
        for (int v = 0; v < 256; v++) push_op(1, 8'(v));
        run_idle(3000);
        check("sweep_eval_count", 32'(bus.eval_count), 32'd256);
        check("sweep_rsp_count", 32'(obs_y.size()), 32'd256);

        // Random mixed traffic
        clear_logs();
        vprob = 50;
        rprob = 70;
        for (int n = 0; n < 400; n++) push_op($urandom_range(NREQ - 1), 8'($urandom));
        run_idle(6000);
        check("random_rsp_count", 32'(obs_y.size()), 32'd400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
